// File: rtl/led_pkg.sv
// Shared types for the LED fade/PWM path.
//   fade_state_t : controller FSM states (IDLE -> RAMP -> DONE -> IDLE)
//   fade_mode_t  : ramp law, LINEAR (+/- step) or EXP (shift-based, perceptual)
// The PWM/LED top and the test bench also use these types.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } fade_state_t;

  typedef enum logic {
    LINEAR = 1'b0,
    EXP    = 1'b1
  } fade_mode_t;

endpackage

// File: rtl/led_fade_ctrl_tick_gen.sv
// tick_gen: free-running prescaler for the fade controller.
//   clk  in  : clock
//   rst  in  : asynchronous active-high reset, counter -> 0
//   clr  in  : synchronous clear, counter -> 0 (restarts the tick period)
//   tick out : high for the single cycle in which the counter is all-ones, so
//              the edge that ends that cycle wraps the counter to zero
// The tick period is 2**PRESC_BITS clk cycles, measured from the last clear.
module tick_gen #(
  parameter int PRESC_BITS = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [PRESC_BITS-1:0] cnt_q;

  // NOTE: registers are updated with non-blocking assignments so every
  // always_ff block samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PRESC_BITS'(1);
    end
  end

  assign tick = &cnt_q;

endmodule

// File: rtl/led_fade_ctrl.sv
// led_fade_ctrl: duty source for the PWM LED stage.
// Accepts a fade command (target duty, ramp mode, step size) over valid/ready
// and ramps the duty output toward the target, one step per prescaler tick.
//   clk         in  : clock, all logic on posedge
//   rst         in  : asynchronous active-high reset (aborts any fade)
//   cmd_valid   in  : command present
//   cmd_ready   out : command can be accepted (IDLE only)
//   cmd_target  in  : duty to reach
//   cmd_mode    in  : 0 = LINEAR, 1 = EXP
//   cmd_step    in  : LINEAR increment (0 behaves as 1), ignored in EXP
//   duty        out : registered duty to the PWM
//   busy        out : ramp in progress
//   done        out : one-cycle pulse once the target has been reached
module led_fade_ctrl
  import led_pkg::*;
#(
  parameter int DUTY_BITS  = 19,
  parameter int PRESC_BITS = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [DUTY_BITS-1:0] cmd_target,
  input  logic                 cmd_mode,
  input  logic [DUTY_BITS-1:0] cmd_step,
  output logic [DUTY_BITS-1:0] duty,
  output logic                 busy,
  output logic                 done
);

  fade_state_t          state_q, state_d;
  fade_mode_t           mode_q, mode_d;
  logic [DUTY_BITS-1:0] duty_q, duty_d;
  logic [DUTY_BITS-1:0] target_q, target_d;
  logic [DUTY_BITS-1:0] step_q, step_d;

  logic                 tick;
  logic                 presc_clr;
  logic                 going_up;
  logic [DUTY_BITS:0]   lin_sum;    // one extra bit so the sum cannot wrap
  logic [DUTY_BITS:0]   lin_diff;   // MSB set means the subtraction borrowed
  logic [DUTY_BITS:0]   exp_up;     // (duty << 1) | 1 without losing the top bit
  logic [DUTY_BITS-1:0] exp_down;
  logic [DUTY_BITS-1:0] next_duty;

  tick_gen #(
    .PRESC_BITS(PRESC_BITS)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (presc_clr),
    .tick(tick)
  );

  // Candidate duty for the next tick, always clamped at the target so the
  // ramp is monotonic and can never overshoot.
  // NOTE: every signal assigned in an always_comb gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    going_up  = target_q > duty_q;
    lin_sum   = {1'b0, duty_q} + {1'b0, step_q};
    lin_diff  = {1'b0, duty_q} - {1'b0, step_q};
    exp_up    = {duty_q, 1'b1};
    exp_down  = duty_q >> 1;
    next_duty = target_q;
    if (mode_q == LINEAR) begin
      if (going_up) begin
        if (lin_sum < {1'b0, target_q}) next_duty = lin_sum[DUTY_BITS-1:0];
      end else begin
        if (!lin_diff[DUTY_BITS] && (lin_diff[DUTY_BITS-1:0] > target_q))
          next_duty = lin_diff[DUTY_BITS-1:0];
      end
    end else begin
      if (going_up) begin
        if (exp_up < {1'b0, target_q}) next_duty = exp_up[DUTY_BITS-1:0];
      end else begin
        if (exp_down > target_q) next_duty = exp_down;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    duty_d    = duty_q;
    target_d  = target_q;
    step_d    = step_q;
    presc_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          target_d  = cmd_target;
          mode_d    = fade_mode_t'(cmd_mode);
          step_d    = (cmd_step == '0) ? DUTY_BITS'(1) : cmd_step;
          presc_clr = 1'b1;  // first step lands a full tick period after accept
          state_d   = (cmd_target == duty_q) ? DONE : RAMP;
        end
      end
      RAMP: begin
        if (tick) begin
          duty_d = next_duty;
          if (next_duty == target_q) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= LINEAR;
      duty_q   <= '0;
      target_q <= '0;
      step_q   <= DUTY_BITS'(1);
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      step_q   <= step_d;
    end
  end

  // All outputs come straight from registers or a decode of the state register.
  assign duty      = duty_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RAMP);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Directed bench for led_fade_ctrl with DUTY_BITS=8, PRESC_BITS=2 (tick every
// 4 cycles). Inputs change and outputs are sampled 1 time unit after posedge.
module tb_led_fade_ctrl;
  import led_pkg::*;

  localparam int DB  = 8;
  localparam int PB  = 2;
  localparam int PER = 4;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DB-1:0] cmd_target;
  logic          cmd_mode;
  logic [DB-1:0] cmd_step;
  logic [DB-1:0] duty;
  logic          busy;
  logic          done;

  int            tests = 0;
  int            fails = 0;
  logic [DB-1:0] cur_duty;
  logic [DB-1:0] exp_q[$];

  led_fade_ctrl #(
    .DUTY_BITS (DB),
    .PRESC_BITS(PB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_target(cmd_target),
    .cmd_mode  (cmd_mode),
    .cmd_step  (cmd_step),
    .duty      (duty),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present a command, wait (bounded) for it to be accepted, then drop valid.
  task automatic send(input string tag, input logic [DB-1:0] tgt, input logic mode,
                      input logic [DB-1:0] stp);
    int waited = 0;
    while (!cmd_ready && waited < 64) begin
      step();
      waited++;
    end
    chk({tag, "_ready_before_accept"}, cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_target = tgt;
    cmd_mode   = mode;
    cmd_step   = stp;
    step();
    cmd_valid  = 1'b0;
    chk({tag, "_ready_after_accept"}, cmd_ready, 0);
  endtask

  // Follow the ramp through exp_q: duty holds for PER-1 cycles, then moves.
  task automatic ramp(input string tag);
    bit last;
    foreach (exp_q[i]) begin
      repeat (PER - 1) begin
        step();
        chk({tag, "_hold_duty"}, duty, cur_duty);
        chk({tag, "_hold_ready"}, cmd_ready, 0);
      end
      step();
      cur_duty = exp_q[i];
      last     = (i == exp_q.size() - 1);
      chk({tag, "_tick_duty"}, duty, cur_duty);
      chk({tag, "_done"}, done, last);
      chk({tag, "_busy"}, busy, !last);
    end
    step();
    chk({tag, "_done_clear"}, done, 0);
    chk({tag, "_ready_back"}, cmd_ready, 1);
    chk({tag, "_duty_final"}, duty, cur_duty);
  endtask

  initial begin
    rst        = 1'b0;
    cmd_valid  = 1'b0;
    cmd_target = '0;
    cmd_mode   = 1'b0;
    cmd_step   = '0;
    cur_duty   = '0;

    // 1: asynchronous reset takes effect before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_duty", duty, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_release_duty", duty, 0);
    chk("rst_release_ready", cmd_ready, 1);

    // 3: EXP ramps up, down, and clamped at a non-power-of-two target
    send("exp_up", 8'd255, 1'b1, 8'd0);
    chk("exp_up_busy", busy, 1);
    exp_q = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd63, 8'd127, 8'd255};
    ramp("exp_up");
    send("exp_down", 8'd0, 1'b1, 8'd0);
    exp_q = '{8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0};
    ramp("exp_down");
    send("exp_clamp", 8'd20, 1'b1, 8'd0);
    exp_q = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd20};
    ramp("exp_clamp");

    // 4: LINEAR, including step=0, borrow clamp and carry clamp
    send("lin_to245", 8'd245, 1'b0, 8'd225);
    exp_q = '{8'd245};
    ramp("lin_to245");
    send("lin_step0", 8'd250, 1'b0, 8'd0);
    exp_q = '{8'd246, 8'd247, 8'd248, 8'd249, 8'd250};
    ramp("lin_step0");
    send("lin_borrow", 8'd3, 1'b0, 8'd255);
    exp_q = '{8'd3};
    ramp("lin_borrow");
    send("lin_to250", 8'd250, 1'b0, 8'd247);
    exp_q = '{8'd250};
    ramp("lin_to250");
    send("lin_carry", 8'd255, 1'b0, 8'd255);
    exp_q = '{8'd255};
    ramp("lin_carry");
    send("lin_to10", 8'd10, 1'b0, 8'd245);
    exp_q = '{8'd10};
    ramp("lin_to10");

    // 5a: target equal to duty goes straight to DONE, no tick delay
    send("eq", 8'd10, 1'b0, 8'd4);
    chk("eq_done", done, 1);
    chk("eq_busy", busy, 0);
    chk("eq_duty", duty, 10);
    step();
    chk("eq_done_clear", done, 0);
    chk("eq_ready", cmd_ready, 1);

    // 5b: command held during RAMP/DONE is taken on the first IDLE cycle
    send("hold_first", 8'd18, 1'b0, 8'd4);
    cmd_valid  = 1'b1;
    cmd_target = 8'd0;
    cmd_mode   = 1'b0;
    cmd_step   = 8'd10;
    exp_q = '{8'd14, 8'd18};
    ramp("hold_first");
    step();
    cmd_valid = 1'b0;
    chk("hold_accepted_ready", cmd_ready, 0);
    chk("hold_accepted_busy", busy, 1);
    chk("hold_accepted_duty", duty, 18);
    exp_q = '{8'd8, 8'd0};
    ramp("hold_second");

    // 6: reset mid-ramp aborts without a done pulse
    send("abort", 8'd10, 1'b0, 8'd4);
    repeat (2 * PER) step();
    chk("abort_pre_duty", duty, 8);
    chk("abort_pre_busy", busy, 1);
    #3 rst = 1'b1;
    #1;
    chk("abort_duty", duty, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    step();
    rst = 1'b0;
    cur_duty = '0;
    repeat (6) begin
      step();
      chk("abort_no_done", done, 0);
      chk("abort_duty_idle", duty, 0);
    end
    send("after_abort", 8'd3, 1'b1, 8'd0);
    exp_q = '{8'd1, 8'd3};
    ramp("after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
